// File: rtl/seven_seg.sv
// Four-digit multiplexed seven-segment driver for a common-anode display.
// Scans ASCII characters onto a shared active-low segment bus.
module seven_seg #(
    parameter int CNT_WIDTH = 18
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] display_0,
    input  logic [7:0] display_1,
    input  logic [7:0] display_2,
    input  logic [7:0] display_3,
    input  logic [1:0] decplace,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cnt;
    logic [1:0]           sel;
    logic [7:0]           chr;
    logic [7:0]           upper;
    logic [6:0]           glyph;
    logic [3:0]           an_next;
    logic [7:0]           seg_next;

    assign sel = cnt[CNT_WIDTH-1 -: 2];

    always_comb begin
        chr = display_0;
        unique case (sel)
            2'd0: chr = display_0;
            2'd1: chr = display_1;
            2'd2: chr = display_2;
            2'd3: chr = display_3;
        endcase
    end

    // Fold lowercase onto uppercase so both share one glyph entry
    always_comb begin
        upper = chr;
        if (chr >= 8'h61 && chr <= 8'h7A)
            upper = chr - 8'h20;
    end

    always_comb begin
        glyph = 7'h7F;
        case (upper)
            "0": glyph = 7'h40;
            "1": glyph = 7'h79;
            "2": glyph = 7'h24;
            "3": glyph = 7'h30;
            "4": glyph = 7'h19;
            "5": glyph = 7'h12;
            "6": glyph = 7'h02;
            "7": glyph = 7'h78;
            "8": glyph = 7'h00;
            "9": glyph = 7'h10;
            "A": glyph = 7'h08;
            "B": glyph = 7'h03;
            "C": glyph = 7'h46;
            "D": glyph = 7'h21;
            "E": glyph = 7'h06;
            "F": glyph = 7'h0E;
            "G": glyph = 7'h42;
            "H": glyph = 7'h09;
            "I": glyph = 7'h79;
            "J": glyph = 7'h61;
            "L": glyph = 7'h47;
            "N": glyph = 7'h2B;
            "O": glyph = 7'h23;
            "P": glyph = 7'h0C;
            "R": glyph = 7'h2F;
            "S": glyph = 7'h12;
            "T": glyph = 7'h07;
            "U": glyph = 7'h41;
            "Y": glyph = 7'h11;
            "-": glyph = 7'h3F;
            "_": glyph = 7'h77;
            default: glyph = 7'h7F;
        endcase
    end

    // display_0 drives the leftmost anode, an[3]
    assign an_next  = ~(4'b1000 >> sel);
    assign seg_next = {(sel != decplace), glyph};

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            cnt <= '0;
            an  <= 4'hF;
            seg <= 8'hFF;
        end else begin
            cnt <= cnt + ONE;
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seven_seg.sv
// Randomized self-checking bench for seven_seg against a behavioural
// model of the scan sequence and glyph table.
module tb_seven_seg;

    localparam int W     = 4;
    localparam int SLOT  = 1 << (W - 2);
    localparam int FRAME = 1 << W;

    localparam logic [8*31-1:0] KEYS = "0123456789ABCDEFGHIJLNOPRSTUY-_";
    localparam logic [6:0] VALS [31] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
        7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h42, 7'h09, 7'h79, 7'h61,
        7'h47, 7'h2B, 7'h23, 7'h0C, 7'h2F, 7'h12, 7'h07, 7'h41, 7'h11,
        7'h3F, 7'h77};

    localparam logic [3:0] SCAN_AN  [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [7:0] SCAN_SEG [4] = '{8'hF9, 8'hA4, 8'h30, 8'h99};

    localparam logic [7:0] SPOT_CODE [5] = '{8'h48, 8'h68, 8'h20, 8'h00, 8'hFF};
    localparam logic [6:0] SPOT_GLY  [5] = '{7'h09, 7'h09, 7'h7F, 7'h7F, 7'h7F};

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] d0 = 8'h20, d1 = 8'h20, d2 = 8'h20, d3 = 8'h20;
    logic [1:0] decplace = 2'd0;
    logic [7:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_seg #(.CNT_WIDTH(W)) dut (
        .clk(clk),
        .rstn(rstn),
        .display_0(d0),
        .display_1(d1),
        .display_2(d2),
        .display_3(d3),
        .decplace(decplace),
        .seg(seg),
        .an(an)
    );

    function automatic logic [6:0] ref_glyph(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (c >= 8'h61 && c <= 8'h7A) u = c - 8'd32;
        for (int i = 0; i < 31; i++)
            if (u == KEYS[8*(30-i) +: 8]) return VALS[i];
        return 7'h7F;
    endfunction

    // Model: ticks since reset pick the digit by integer division
    int         mtick;
    logic [3:0] m_an;
    logic [7:0] m_seg;
    always @(posedge clk or posedge rstn) begin
        int d;
        logic [7:0] c;
        if (rstn) begin
            mtick = 0;
            m_an  = 4'hF;
            m_seg = 8'hFF;
        end else begin
            d = (mtick % FRAME) / SLOT;
            c = (d == 0) ? d0 : (d == 1) ? d1 : (d == 2) ? d2 : d3;
            m_an = 4'hF;
            m_an[3-d] = 1'b0;
            m_seg = {(int'(decplace) == d) ? 1'b0 : 1'b1, ref_glyph(c)};
            mtick = mtick + 1;
        end
    end

    task automatic test_reset();
        #2 rstn = 1'b1;
        #1;
        checks++;
        if (an !== 4'hF) begin
            errors++;
            $display("FAIL reset_an got %b want 1111", an);
        end
        checks++;
        if (seg !== 8'hFF) begin
            errors++;
            $display("FAIL reset_seg got %h want ff", seg);
        end
        d0 = "8"; d1 = "8"; d2 = "8"; d3 = "8";
        @(negedge clk) rstn = 1'b0;
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 8'hFF) begin
            errors++;
            $display("FAIL async_reset got an=%b seg=%h want 1111/ff", an, seg);
        end
        @(posedge clk);
        #1;
        checks++;
        if (an !== 4'hF || seg !== 8'hFF) begin
            errors++;
            $display("FAIL held_reset got an=%b seg=%h want 1111/ff", an, seg);
        end
    endtask

    task automatic test_scan();
        d0 = "1"; d1 = "2"; d2 = "3"; d3 = "4";
        decplace = 2'b10;
        @(negedge clk) rstn = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            int d;
            @(negedge clk);
            d = (i / SLOT) % 4;
            checks++;
            if (an !== SCAN_AN[d] || seg !== SCAN_SEG[d]) begin
                errors++;
                $display("FAIL scan[%0d] got an=%b seg=%h want %b/%h",
                         i, an, seg, SCAN_AN[d], SCAN_SEG[d]);
            end
        end
    endtask

    task automatic test_glyph();
        for (int code = 0; code < 256; code++) begin
            @(negedge clk);
            d0 = code[7:0]; d1 = code[7:0]; d2 = code[7:0]; d3 = code[7:0];
            @(negedge clk);
            checks++;
            if (seg[6:0] !== ref_glyph(code[7:0])) begin
                errors++;
                $display("FAIL glyph[%h] got %h want %h",
                         code[7:0], seg[6:0], ref_glyph(code[7:0]));
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            d0 = SPOT_CODE[k]; d1 = SPOT_CODE[k];
            d2 = SPOT_CODE[k]; d3 = SPOT_CODE[k];
            @(negedge clk);
            checks++;
            if (seg[6:0] !== SPOT_GLY[k]) begin
                errors++;
                $display("FAIL glyph_spot[%h] got %h want %h",
                         SPOT_CODE[k], seg[6:0], SPOT_GLY[k]);
            end
        end
    endtask

    task automatic test_decpoint();
        d0 = "0"; d1 = "1"; d2 = "2"; d3 = "3";
        for (int dp = 0; dp < 4; dp++) begin
            int lit;
            int bad;
            logic [3:0] want;
            lit = 0;
            bad = 0;
            want = 4'hF;
            want[3-dp] = 1'b0;
            @(negedge clk) decplace = dp[1:0];
            @(negedge clk);
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                if (!seg[7]) begin
                    lit++;
                    if (an !== want) bad++;
                end
            end
            checks++;
            if (lit != SLOT || bad != 0) begin
                errors++;
                $display("FAIL decpoint[%0d] got lit=%0d wrong=%0d want %0d/0",
                         dp, lit, bad, SLOT);
            end
        end
    endtask

    task automatic test_live_update();
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        @(negedge clk);
        d1 = "A";
        decplace = 2'd0;
        prev = an;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            @(negedge clk);
            if (an === 4'b1011 && prev !== 4'b1011) found = 1'b1;
            else prev = an;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL live_timeout got no digit-1 slot want one");
        end else begin
            if (seg[6:0] !== 7'h08) begin
                errors++;
                $display("FAIL live_before got %h want 08", seg[6:0]);
            end
            d1 = "E";
            @(negedge clk);
            checks++;
            if (an !== 4'b1011 || seg[6:0] !== 7'h06) begin
                errors++;
                $display("FAIL live_after got an=%b seg=%h want 1011/06",
                         an, seg[6:0]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] hist [3*FRAME];
        int bad_model;
        int bad_period;
        bad_model = 0;
        bad_period = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            hist[i] = an;
            if (an !== m_an || seg !== m_seg) bad_model++;
        end
        for (int i = FRAME; i < 3 * FRAME; i++)
            if (hist[i] !== hist[i-FRAME]) bad_period++;
        checks++;
        if (bad_model != 0) begin
            errors++;
            $display("FAIL wrap_model got %0d diffs want 0", bad_model);
        end
        checks++;
        if (bad_period != 0) begin
            errors++;
            $display("FAIL wrap_period got %0d diffs want 0", bad_period);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (an !== m_an || seg !== m_seg) begin
                errors++;
                $display("FAIL random[%0d] got an=%b seg=%h want %b/%h",
                         i, an, seg, m_an, m_seg);
            end
            if ($urandom_range(0, 3) == 0) d0 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) d1 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) d2 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) d3 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) decplace = 2'($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_glyph();
        test_decpoint();
        test_live_update();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg.md
# seven_seg

Four-digit multiplexed seven-segment display driver for the board's common-anode display. It takes four ASCII character codes plus a decimal-point position and time-multiplexes them onto the shared segment bus and the per-digit anode enables. It sits under the UART command parser, which feeds it a scrolling text banner.

## Interface
- `CNT_WIDTH`, default 18: refresh counter width. The digit changes every 2^(CNT_WIDTH-2) clocks; the full 4-digit frame is 2^CNT_WIDTH clocks. Must be ≥ 3.
- `clk` input, 1 bit: system clock. Everything is on the rising edge.
- `rstn` input, 1 bit: reset. One clock; reset is asynchronous and active-high. The port keeps the codebase name `rstn`, but it asserts when high.
- `display_0` input, 8 bits: ASCII character for the leftmost digit (anode `an[3]`).
- `display_1` input, 8 bits: ASCII character for digit 1 (`an[2]`).
- `display_2` input, 8 bits: ASCII character for digit 2 (`an[1]`).
- `display_3` input, 8 bits: ASCII character for the rightmost digit (`an[0]`).
- `decplace` input, 2 bits: index N of the `display_N` digit whose decimal point is lit.
- `seg` output, 8 bits: segments, active-low, ordered {dp, g, f, e, d, c, b, a}.
- `an` output, 4 bits: digit anodes, active-low, one-hot-low while running.

## Operation
- Refresh counter `cnt` (CNT_WIDTH bits):
  - increments by 1 every clock and wraps from all-ones to 0;
  - `sel = cnt[CNT_WIDTH-1:CNT_WIDTH-2]` selects the active digit `display_sel`.
- Selected digit outputs:
  - `an` is all ones except bit `3-sel`, which is 0.
  - `seg[6:0]` is the glyph of `display_sel`.
  - `seg[7]` is 0 when `sel == decplace`, else 1.
- Inputs are sampled continuously with no latching. A character change appears the next time that digit is selected.
- Glyph table, seg[6:0] in hex, active-low:
  - digits: '0' 40, '1' 79, '2' 24, '3' 30, '4' 19, '5' 12, '6' 02, '7' 78, '8' 00, '9' 10;
  - letters: 'A' 08, 'b' 03, 'C' 46, 'd' 21, 'E' 06, 'F' 0E, 'G' 42, 'H' 09, 'I' 79, 'J' 61, 'L' 47, 'n' 2B, 'o' 23, 'P' 0C, 'r' 2F, 'S' 12, 't' 07, 'U' 41, 'y' 11;
  - punctuation: '-' 3F, '_' 77;
  - lowercase and uppercase of the same letter map to the same glyph;
  - space, and every code not listed above (including 0x00, control codes and ≥0x80), maps to 7F (blank).
- Reset while asserted:
  - `cnt = 0`, `an = 4'b1111` (all digits off), `seg = 8'hFF`;
  - reset takes effect immediately, asynchronously, in mid-frame or mid-digit.
- No other state. There is no enable and no brightness control.

## Timing
- `seg` and `an` are registered and are computed from the current `cnt` and current inputs. They therefore lag `cnt` by exactly one clock.
- After reset deasserts:
  - first rising edge: `cnt` 0→1; outputs load digit 0 (`an = 1110`? no — `an = 0111`, i.e. `an[3]` low, with glyph of `display_0`);
  - digit 0 is shown for 2^(CNT_WIDTH-2) clocks, then digits 1, 2, 3 in turn, then back to 0;
  - order is fixed: display_0 → display_1 → display_2 → display_3 → display_0.
- Input-to-output latency is one clock while that digit is active. A change to `display_k` during digit k's slot shows on `seg` on the next edge.
- On each digit boundary, `an` and `seg` switch on the same edge. No blanking gap is required.
- `decplace` changes follow the same one-clock latency.

## Test plan
- **Reset:** with CNT_WIDTH=4, hold `rstn` high. Require `an=1111` and `seg=FF`, including when reset is asserted asynchronously mid-cycle, with no clock edge needed.
- **Scan order:** CNT_WIDTH=4; display_0..3 = "1","2","3","4"; decplace=2'b10; release reset.
  - Require `an` to step 0111, 1011, 1101, 1110, each held 4 clocks, repeating.
  - Require `seg` = F9, A4, 30, 99 respectively; digit 2 shows dp bit 0, so `seg` = 30 there rather than B0.
- **Glyph sweep:** drive all 256 codes on display_0 and check `seg[6:0]` against the table. Require "H"→09, "h"→09, " "→7F, 0x00→7F, 0xFF→7F.
- **Decimal point:** sweep decplace 0..3. Require exactly one digit per frame to have `seg[7]=0`, and that it is the selected digit index.
- **Live update:** change display_1 from "A" to "E" while digit 1 is active. Require `seg` to go from 08 to 06 on the next clock edge.
- **Wrap:** run 3 full frames (48 clocks at CNT_WIDTH=4). Require a continuous period-16 `an` pattern with no glitch at the counter wrap.
